rep_add_mult: RTL and testbench



---
 rtl/rep_add_mult.sv | 110 +++++++++++
 tb/tb_rep_add_mult.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rep_add_mult.sv
// Sequential unsigned multiplier by repeated addition, with start/busy/done handshake.
// Optional build macro REP_ADD_MULT_SWAP_EN loads the smaller operand into the counter.
module rep_add_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    p_q, p_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] ld_a, ld_b;

    // Operand steering at load time: counter gets the smaller value when swapping is built in
`ifdef REP_ADD_MULT_SWAP_EN
    always_comb begin
        ld_a = a_in;
        ld_b = b_in;
        if (a_in < b_in) begin
            ld_a = b_in;
            ld_b = a_in;
        end
    end
`else
    always_comb begin
        ld_a = a_in;
        ld_b = b_in;
    end
`endif

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = {{WIDTH{1'b0}}, ld_a};
                    b_d     = ld_b;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                p_d     = '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                if (b_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    p_d = p_q + a_q;
                    b_d = b_q - WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Outputs are registered, so they follow the state being entered
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign product = p_q;

endmodule

// File: tb/tb_rep_add_mult.sv
// Directed self-checking bench for rep_add_mult (WIDTH=8), both swap builds.
module tb_rep_add_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a_in, b_in;
    logic        busy, done;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;

    rep_add_mult #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_n(input int a, input int b);
`ifdef REP_ADD_MULT_SWAP_EN
        return (a < b) ? a : b;
`else
        return b;
`endif
    endfunction

    // Runs one operation starting at a negedge (cycle 0); optional start re-pulses in cycles 2 and 4
    task automatic run_op(input string tag, input int a, input int b, input bit repulse);
        int done_cyc;
        int busy_low;
        int done_cnt;
        int exp_lat;
        exp_lat  = exp_n(a, b) + 3;
        done_cyc = -1;
        busy_low = 0;
        done_cnt = 0;
        a_in  = 8'(a);
        b_in  = 8'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (repulse && (k == 2 || k == 4)) begin
                start = 1'b1;
                a_in  = 8'd1;
                b_in  = 8'd1;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_low++;
            if (done) begin
                done_cyc = k;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(done_cyc), 32'(exp_lat));
        check({tag, " product"}, 32'(product), 32'(a * b));
        check({tag, " busy_held"}, 32'(busy_low), 32'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " busy_fall"}, 32'(busy), 32'd0);
        if (repulse) begin
            for (int k = 0; k < 20; k++) begin
                if (done) done_cnt++;
                @(negedge clk);
            end
            check({tag, " no_extra_done"}, 32'(done_cnt), 32'd0);
            check({tag, " product_held"}, 32'(product), 32'(a * b));
        end
    endtask

    initial begin
        int done_cnt;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("3x5", 3, 5, 1'b0);
        run_op("200x0", 200, 0, 1'b0);
        run_op("255x255", 255, 255, 1'b0);
        run_op("7x6 repulse", 7, 6, 1'b1);
        run_op("after repulse 4x3", 4, 3, 1'b0);

        // Reset in cycle 4 of 9x9 aborts the operation
        a_in  = 8'd9;
        b_in  = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort product", 32'(product), 32'd0);
        check("abort done", 32'(done), 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort no_done", 32'(done_cnt), 32'd0);
        run_op("2x3 after abort", 2, 3, 1'b0);

        // Reset wins over start in the same cycle
        a_in  = 8'd5;
        b_in  = 8'd5;
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        check("rst+start busy", 32'(busy), 32'd0);
        check("rst+start product", 32'(product), 32'd0);
        @(negedge clk);
        check("rst+start idle", 32'(busy), 32'd0);
        check("rst+start done", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
